// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game logic and its renderer.
// Also holds the LFSR step and the rule that maps a random value onto an oval.
package mole_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GAP,
      ST_UP,
      ST_HIT,
      ST_MISS,
      ST_OVER
   } state_e;

   localparam logic [2:0] NO_MOLE   = 3'd7;
   localparam int         NUM_OVALS = 5;

   // Oval centres on the 640x480 frame; the renderer draws around these.
   function automatic int unsigned oval_cx(input logic [2:0] idx);
      case (idx)
         3'd0:    return 32'd80;
         3'd1:    return 32'd200;
         3'd2:    return 32'd320;
         3'd3:    return 32'd440;
         3'd4:    return 32'd560;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int unsigned oval_cy(input logic [2:0] idx);
      return (idx < 3'(NUM_OVALS)) ? 32'd300 : 32'd0;
   endfunction

   // 8-bit Fibonacci LFSR, taps 8,6,5,4.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Fold 0..7 onto 0..4, then step past the previous oval so a mole never repeats.
   function automatic logic [2:0] pick_oval(input logic [2:0] raw, input logic [2:0] prev);
      logic [2:0] c;
      c = (raw >= 3'(NUM_OVALS)) ? raw - 3'(NUM_OVALS) : raw;
      if (c == prev) begin
         c = (c == 3'(NUM_OVALS - 1)) ? 3'd0 : c + 3'd1;
      end
      return c;
   endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Player/renderer side of the mole scheduler: button and start inputs, game status outputs.
// master drives start/btn and observes; slave is the scheduler.
interface mole_scheduler_if #(
   parameter int SCORE_W = 8
);
   logic               start;
   logic [4:0]         btn;
   logic [2:0]         oval_select;
   logic               mole_active;
   logic               hit_pulse;
   logic               miss_pulse;
   logic [SCORE_W-1:0] score;
   logic [3:0]         misses;
   logic               game_over;

   modport master (
      output start, btn,
      input  oval_select, mole_active, hit_pulse, miss_pulse, score, misses, game_over
   );

   modport slave (
      input  start, btn,
      output oval_select, mole_active, hit_pulse, miss_pulse, score, misses, game_over
   );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer per push-button followed by a registered rising-edge detector.
// A button sampled high at edge k yields edge_o high for cycle k+2..k+3.
module btn_sync_edge #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] btn_i,
   output logic [W-1:0] edge_o
);

   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;
   logic [W-1:0] sync2_dly_q;
   logic [W-1:0] edge_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         sync2_dly_q <= '0;
         edge_q      <= '0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         sync2_dly_q <= sync2_q;
         edge_q      <= sync2_q & ~sync2_dly_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/mole_scheduler.sv
// Game FSM: picks a pseudo-random oval, holds the mole up, scores whacks and counts misses.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   GAP     | no mole shown, waiting GAP_TIME cycles
//   UP      | mole shown on sel, waiting for matching button or timeout
//   HIT     | one cycle, hit_pulse, score already bumped
//   MISS    | one cycle, miss_pulse, misses already bumped
//   OVER    | MAX_MISSES reached, waiting for start to replay
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int         UP_TIME    = 12_500_000,
   parameter int         GAP_TIME   = 6_250_000,
   parameter int         CNT_W      = 24,
   parameter logic [7:0] LFSR_SEED  = 8'hA5,
   parameter int         MAX_MISSES = 3,
   parameter int         SCORE_W    = 8
) (
   input logic        clk,
   input logic        rst,
   mole_scheduler_if.slave bus
);

   localparam logic [CNT_W-1:0] UP_LAST    = CNT_W'(UP_TIME - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TIME - 1);
   localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISSES);

   state_e             state_q;
   logic [CNT_W-1:0]   timer_q;
   logic [7:0]         lfsr_q;
   logic [7:0]         lfsr_d;
   logic [2:0]         prev_oval_q;
   logic [2:0]         sel_q;
   logic [2:0]         oval_q;
   logic [SCORE_W-1:0] score_q;
   logic [3:0]         misses_q;
   logic               mole_active_q;
   logic               hit_q;
   logic               miss_q;
   logic               over_q;

   logic [4:0]         btn_edge;
   logic [2:0]         cand;
   logic               gap_done;
   logic               up_done;
   logic               hit_now;

   btn_sync_edge #(.W(5)) u_btn_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.btn),
      .edge_o (btn_edge)
   );

   assign lfsr_d   = lfsr_step(lfsr_q);
   assign cand     = pick_oval(lfsr_q[2:0], prev_oval_q);
   assign gap_done = (timer_q == GAP_LAST);
   assign up_done  = (timer_q == UP_LAST);
   assign hit_now  = btn_edge[sel_q];

   // Free-running in every state so the first mole depends on how long IDLE lasted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         prev_oval_q   <= '0;
         sel_q         <= '0;
         oval_q        <= NO_MOLE;
         score_q       <= '0;
         misses_q      <= '0;
         mole_active_q <= 1'b0;
         hit_q         <= 1'b0;
         miss_q        <= 1'b0;
         over_q        <= 1'b0;
      end else begin
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         timer_q <= timer_q + 1'b1;
         case (state_q)
            ST_IDLE, ST_OVER: begin
               timer_q <= '0;
               if (bus.start) begin
                  score_q  <= '0;
                  misses_q <= '0;
                  over_q   <= 1'b0;
                  state_q  <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_done) begin
                  sel_q         <= cand;
                  prev_oval_q   <= cand;
                  oval_q        <= cand;
                  mole_active_q <= 1'b1;
                  timer_q       <= '0;
                  state_q       <= ST_UP;
               end
            end
            ST_UP: begin
               // A correct whack on the final UP cycle still counts as a hit.
               if (hit_now) begin
                  if (score_q != {SCORE_W{1'b1}}) begin
                     score_q <= score_q + 1'b1;
                  end
                  hit_q         <= 1'b1;
                  mole_active_q <= 1'b0;
                  timer_q       <= '0;
                  state_q       <= ST_HIT;
               end else if (up_done) begin
                  misses_q      <= misses_q + 1'b1;
                  miss_q        <= 1'b1;
                  mole_active_q <= 1'b0;
                  timer_q       <= '0;
                  state_q       <= ST_MISS;
               end
            end
            ST_HIT: begin
               timer_q <= '0;
               oval_q  <= NO_MOLE;
               state_q <= ST_GAP;
            end
            ST_MISS: begin
               timer_q <= '0;
               oval_q  <= NO_MOLE;
               if (misses_q == MISS_LIMIT) begin
                  over_q  <= 1'b1;
                  state_q <= ST_OVER;
               end else begin
                  state_q <= ST_GAP;
               end
            end
            default: begin
               timer_q       <= '0;
               oval_q        <= NO_MOLE;
               mole_active_q <= 1'b0;
               over_q        <= 1'b0;
               state_q       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.oval_select = oval_q;
   assign bus.mole_active = mole_active_q;
   assign bus.hit_pulse   = hit_q;
   assign bus.miss_pulse  = miss_q;
   assign bus.score       = score_q;
   assign bus.misses      = misses_q;
   assign bus.game_over   = over_q;

endmodule
